// File: rtl/vram_read_arbiter.sv
// vram_read_arbiter
// Shares the single AXI4 read port to SDRAM between NUM_PORTS requesters.
// Port 0 (video scanout) has fixed priority, limited by a streak counter so
// that the lower ports always make progress. Ports 1..NUM_PORTS-1 are served
// round-robin. Only one burst is in flight: AR issue, then R beats are routed
// back to the owning port until the last beat.
module vram_read_arbiter #(
    parameter int NUM_PORTS     = 3,
    parameter int HP_STREAK_MAX = 4,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        s_ar_valid,
    output logic [NUM_PORTS-1:0]        s_ar_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] s_ar_addr,
    input  logic [NUM_PORTS*8-1:0]      s_ar_len,
    output logic [NUM_PORTS-1:0]        s_r_valid,
    input  logic [NUM_PORTS-1:0]        s_r_ready,
    output logic [DATA_W-1:0]           s_r_data,
    output logic                        s_r_last,
    output logic                        m_ar_valid,
    input  logic                        m_ar_ready,
    output logic [ADDR_W-1:0]           m_ar_addr,
    output logic [7:0]                  m_ar_len,
    output logic [1:0]                  m_ar_burst,
    input  logic                        m_r_valid,
    output logic                        m_r_ready,
    input  logic [DATA_W-1:0]           m_r_data,
    input  logic                        m_r_last,
    output logic [2:0]                  owner,
    output logic                        busy,
    output logic                        protocol_err
);

    localparam int HP_W = $clog2(HP_STREAK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t            state;
    logic [HP_W-1:0]   hp_streak;
    logic [2:0]        rr_ptr;     // next lower port to favour, always in 1..NUM_PORTS-1
    logic [7:0]        beat_cnt;   // beats still expected after the current one

    logic              lower_valid;
    logic              hp_blocked;
    logic              win_found;
    logic [2:0]        winner;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_len;
    logic              accept;
    logic              r_fire;
    int                rr_idx;

    assign m_ar_burst = 2'b01;

    // Pick the winner among current requests: port 0 unless its streak is
    // exhausted while a lower port waits, otherwise round-robin from rr_ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rr_idx      = 0;
        winner      = '0;
        win_found   = 1'b0;
        lower_valid = |s_ar_valid[NUM_PORTS-1:1];
        hp_blocked  = (hp_streak == HP_W'(HP_STREAK_MAX)) && lower_valid;
        if (s_ar_valid[0] && !hp_blocked) begin
            winner    = 3'd0;
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_PORTS - 1; k++) begin
                rr_idx = ((int'(rr_ptr) - 1 + k) % (NUM_PORTS - 1)) + 1;
                for (int i = 1; i < NUM_PORTS; i++) begin
                    if (!win_found && (i == rr_idx) && s_ar_valid[i]) begin
                        winner    = 3'(i);
                        win_found = 1'b1;
                    end
                end
            end
        end
    end

    // Select the winning port's address and length.
    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winner == 3'(i)) begin
                win_addr = s_ar_addr[i*ADDR_W +: ADDR_W];
                win_len  = s_ar_len[i*8 +: 8];
            end
        end
    end

    assign accept = (state == ST_IDLE) && win_found && !reset;
    assign r_fire = m_r_valid && m_r_ready;

    // Per-port handshakes: accept pulse in IDLE, R routing to the owner in DATA.
    always_comb begin
        s_ar_ready = '0;
        s_r_valid  = '0;
        m_r_ready  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_ar_ready[i] = accept && (winner == 3'(i));
            if ((state == ST_DATA) && (owner == 3'(i))) begin
                s_r_valid[i] = m_r_valid;
                m_r_ready    = s_r_ready[i];
            end
        end
    end

    assign s_r_data = (state == ST_DATA) ? m_r_data : '0;
    assign s_r_last = (state == ST_DATA) && m_r_last;

    // Burst sequencer: accept, issue AR, count beats back to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state        <= ST_IDLE;
            m_ar_valid   <= 1'b0;
            m_ar_addr    <= '0;
            m_ar_len     <= '0;
            owner        <= '0;
            busy         <= 1'b0;
            beat_cnt     <= '0;
            hp_streak    <= '0;
            rr_ptr       <= 3'd1;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        m_ar_addr  <= win_addr;
                        m_ar_len   <= win_len;
                        beat_cnt   <= win_len;
                        owner      <= winner;
                        m_ar_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ADDR;
                        if (winner == 3'd0) begin
                            if (!lower_valid)
                                hp_streak <= '0;
                            else if (hp_streak != HP_W'(HP_STREAK_MAX))
                                hp_streak <= hp_streak + 1'b1;
                        end else begin
                            hp_streak <= '0;
                            rr_ptr    <= (winner == 3'(NUM_PORTS - 1)) ? 3'd1 : winner + 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_ar_ready) begin
                        m_ar_valid <= 1'b0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire) begin
                        if (m_r_last) begin
                            // An early last still ends the burst; the mismatch is flagged.
                            if (beat_cnt != 8'd0)
                                protocol_err <= 1'b1;
                            state <= ST_IDLE;
                            owner <= '0;
                            busy  <= 1'b0;
                        end else if (beat_cnt == 8'd0) begin
                            // Slave overran the length: keep routing until it signals last.
                            protocol_err <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Testbench for vram_read_arbiter: requesters and an AXI read slave are
// modelled in the bench; expected grants and beats go through queues.
module tb_vram_read_arbiter;

    localparam int NUM_PORTS     = 3;
    localparam int HP_STREAK_MAX = 4;
    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_PORTS-1:0]        s_ar_valid;
    logic [NUM_PORTS-1:0]        s_ar_ready;
    logic [NUM_PORTS*ADDR_W-1:0] s_ar_addr;
    logic [NUM_PORTS*8-1:0]      s_ar_len;
    logic [NUM_PORTS-1:0]        s_r_valid;
    logic [NUM_PORTS-1:0]        s_r_ready;
    logic [DATA_W-1:0]           s_r_data;
    logic                        s_r_last;
    logic                        m_ar_valid;
    logic                        m_ar_ready;
    logic [ADDR_W-1:0]           m_ar_addr;
    logic [7:0]                  m_ar_len;
    logic [1:0]                  m_ar_burst;
    logic                        m_r_valid;
    logic                        m_r_ready;
    logic [DATA_W-1:0]           m_r_data;
    logic                        m_r_last;
    logic [2:0]                  owner;
    logic                        busy;
    logic                        protocol_err;

    vram_read_arbiter #(
        .NUM_PORTS    (NUM_PORTS),
        .HP_STREAK_MAX(HP_STREAK_MAX),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_ar_valid  (s_ar_valid),
        .s_ar_ready  (s_ar_ready),
        .s_ar_addr   (s_ar_addr),
        .s_ar_len    (s_ar_len),
        .s_r_valid   (s_r_valid),
        .s_r_ready   (s_r_ready),
        .s_r_data    (s_r_data),
        .s_r_last    (s_r_last),
        .m_ar_valid  (m_ar_valid),
        .m_ar_ready  (m_ar_ready),
        .m_ar_addr   (m_ar_addr),
        .m_ar_len    (m_ar_len),
        .m_ar_burst  (m_ar_burst),
        .m_r_valid   (m_r_valid),
        .m_r_ready   (m_r_ready),
        .m_r_data    (m_r_data),
        .m_r_last    (m_r_last),
        .owner       (owner),
        .busy        (busy),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        port;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } grant_t;

    typedef struct packed {
        logic [2:0]        port;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    grant_t exp_grants[$];
    beat_t  exp_beats[$];
    grant_t cur;

    int n_cmp = 0;
    int n_bad = 0;

    // requester model
    int         pending[NUM_PORTS];
    int         issued[NUM_PORTS];
    int         planned[NUM_PORTS];
    logic [7:0] port_len[NUM_PORTS];

    // AXI slave model
    bit                r_active;
    logic [ADDR_W-1:0] r_addr;
    int                r_idx;
    int                r_last_idx;
    int                ar_delay;
    int                ar_wait;
    int                err_last_idx;   // -1: slave marks last correctly

    bit toggle_rready;
    bit rready_phase;
    bit in_data;
    bit expect_idle;
    int beats_seen;
    int t2_order[10];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] req_addr(input int p, input int k);
        return ADDR_W'(p << 20) | ADDR_W'(k << 8);
    endfunction

    function automatic bit pending_any();
        bit any;
        any = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (pending[p] > 0) any = 1'b1;
        return any;
    endfunction

    task automatic plan_grant(input int p);
        grant_t g;
        g.port = 3'(p);
        g.addr = req_addr(p, planned[p]);
        g.len  = port_len[p];
        planned[p]++;
        exp_grants.push_back(g);
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NUM_PORTS; p++) begin
            s_ar_valid[p]                  = (pending[p] > 0);
            s_ar_addr[p*ADDR_W +: ADDR_W]  = req_addr(p, issued[p]);
            s_ar_len[p*8 +: 8]             = port_len[p];
        end
        if (m_ar_valid === 1'b1) begin
            m_ar_ready = (ar_wait >= ar_delay);
            ar_wait++;
        end else begin
            m_ar_ready = 1'b0;
            ar_wait    = 0;
        end
        m_r_valid = r_active;
        m_r_data  = r_addr + ADDR_W'(r_idx * 4);
        m_r_last  = r_active && (r_idx == r_last_idx);
        if (toggle_rready) rready_phase = !rready_phase;
        else               rready_phase = 1'b1;
        s_r_ready = rready_phase ? '1 : '0;
    endtask

    task automatic observe();
        grant_t               g;
        beat_t                b;
        int                   gp;
        int                   rp;
        int                   nb;
        logic                 exp_mr;
        logic [NUM_PORTS-1:0] exp_sv;
        if (reset) return;
        if (expect_idle) begin
            check("busy_after_last", busy, 1'b0);
            check("owner_after_last", owner, 3'd0);
            expect_idle = 1'b0;
        end
        if (in_data) begin
            exp_mr = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                exp_sv[p] = m_r_valid && (p == int'(cur.port));
                if (p == int'(cur.port)) exp_mr = s_r_ready[p];
            end
            check("m_r_ready_mirror", m_r_ready, exp_mr);
            check("s_r_valid_route", s_r_valid, exp_sv);
        end else begin
            check("s_r_valid_quiet", s_r_valid, '0);
        end
        if ((s_ar_ready & s_ar_valid) != '0) begin
            check("ar_ready_onehot", $countones(s_ar_ready), 1);
            gp = 0;
            for (int p = 0; p < NUM_PORTS; p++)
                if (s_ar_ready[p]) gp = p;
            if (exp_grants.size() == 0) begin
                check("grant_unexpected", s_ar_ready, '0);
            end else begin
                g = exp_grants.pop_front();
                check("grant_port", gp, g.port);
                cur = g;
                nb = (err_last_idx >= 0) ? err_last_idx + 1 : int'(g.len) + 1;
                for (int k = 0; k < nb; k++) begin
                    b.port = g.port;
                    b.data = g.addr + ADDR_W'(k * 4);
                    b.last = (k == nb - 1);
                    exp_beats.push_back(b);
                end
            end
            if (pending[gp] > 0) pending[gp]--;
            issued[gp]++;
        end
        if ((s_r_valid & s_r_ready) != '0) begin
            rp = 0;
            for (int p = 0; p < NUM_PORTS; p++)
                if (s_r_valid[p] && s_r_ready[p]) rp = p;
            beats_seen++;
            if (exp_beats.size() == 0) begin
                check("beat_unexpected", s_r_valid, '0);
            end else begin
                b = exp_beats.pop_front();
                check("beat_port", rp, b.port);
                check("beat_data", s_r_data, b.data);
                check("beat_last", s_r_last, b.last);
                if (b.last) begin
                    in_data     = 1'b0;
                    expect_idle = 1'b1;
                end
            end
        end
        if (m_r_valid && m_r_ready) begin
            if (r_idx == r_last_idx) r_active = 1'b0;
            else                     r_idx++;
        end
        if (m_ar_valid && m_ar_ready) begin
            check("m_ar_addr", m_ar_addr, cur.addr);
            check("m_ar_len", m_ar_len, cur.len);
            check("m_ar_burst", m_ar_burst, 2'b01);
            r_active   = 1'b1;
            r_addr     = m_ar_addr;
            r_idx      = 0;
            r_last_idx = (err_last_idx >= 0) ? err_last_idx : int'(m_ar_len);
            in_data    = 1'b1;
            ar_wait    = 0;
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled 1 later.
    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        #1;
        observe();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_grants.size() != 0 || exp_beats.size() != 0 || in_data || pending_any())
               && n < budget) begin
            step();
            n++;
        end
        check(tag, n < budget, 1'b1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        s_ar_valid = '0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_r_ready  = '0;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_last   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pending[p]  = 0;
            issued[p]   = 0;
            planned[p]  = 0;
            port_len[p] = 8'd0;
        end
        r_active      = 1'b0;
        r_addr        = '0;
        r_idx         = 0;
        r_last_idx    = 0;
        ar_delay      = 0;
        ar_wait       = 0;
        err_last_idx  = -1;
        toggle_rready = 1'b0;
        rready_phase  = 1'b1;
        in_data       = 1'b0;
        expect_idle   = 1'b0;
        beats_seen    = 0;
        t2_order      = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 3'd0);
        check("rst_perr", protocol_err, 1'b0);
        check("rst_m_ar_valid", m_ar_valid, 1'b0);
        check("rst_m_ar_addr", m_ar_addr, '0);
        check("rst_m_ar_len", m_ar_len, 8'd0);
        check("rst_m_ar_burst", m_ar_burst, 2'b01);
        check("rst_s_ar_ready", s_ar_ready, '0);
        check("rst_s_r_valid", s_r_valid, '0);
        check("rst_m_r_ready", m_r_ready, 1'b0);
        reset = 1'b0;

        // 1: single request, slave delays AR ready
        ar_delay    = 2;
        port_len[1] = 8'd3;
        pending[1]  = 1;
        plan_grant(1);
        run_until_done("t1_done", 100);
        check("t1_perr", protocol_err, 1'b0);
        ar_delay = 0;

        // 2: port 0 priority bounded by the streak limit
        port_len[0] = 8'd1;
        port_len[2] = 8'd1;
        pending[0]  = 8;
        pending[2]  = 2;
        for (int i = 0; i < 10; i++) plan_grant(t2_order[i]);
        run_until_done("t2_done", 400);

        // 3: round-robin between the lower ports
        port_len[1] = 8'd0;
        port_len[2] = 8'd2;
        pending[1]  = 2;
        pending[2]  = 2;
        plan_grant(1);
        plan_grant(2);
        plan_grant(1);
        plan_grant(2);
        run_until_done("t3_done", 200);

        // 4: R backpressure toggling every cycle
        toggle_rready = 1'b1;
        port_len[2]   = 8'd7;
        pending[2]    = 1;
        plan_grant(2);
        beats_seen = 0;
        run_until_done("t4_done", 200);
        check("t4_beats", beats_seen, 8);
        toggle_rready = 1'b0;

        // 5a: early last on beat 2 of 4
        err_last_idx = 1;
        port_len[1]  = 8'd3;
        pending[1]   = 1;
        plan_grant(1);
        run_until_done("t5a_done", 100);
        check("t5a_perr", protocol_err, 1'b1);

        // 5b: last missing on beat 4, arrives on beat 6
        err_last_idx = 5;
        port_len[2]  = 8'd3;
        pending[2]   = 1;
        plan_grant(2);
        beats_seen = 0;
        n = 0;
        while (beats_seen < 4 && n < 100) begin
            step();
            n++;
        end
        check("t5b_reach", n < 100, 1'b1);
        step();
        check("t5b_busy", busy, 1'b1);
        check("t5b_perr", protocol_err, 1'b1);
        run_until_done("t5b_done", 100);
        err_last_idx = -1;

        // 6: reset in the middle of a burst
        port_len[1] = 8'd7;
        pending[1]  = 1;
        plan_grant(1);
        beats_seen = 0;
        n = 0;
        while (beats_seen < 2 && n < 100) begin
            step();
            n++;
        end
        check("t6_reach", n < 100, 1'b1);
        reset    = 1'b1;
        r_active = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) pending[p] = 0;
        exp_grants.delete();
        exp_beats.delete();
        in_data     = 1'b0;
        expect_idle = 1'b0;
        @(posedge clk);
        #1;
        drive_inputs();
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_owner", owner, 3'd0);
        check("t6_perr", protocol_err, 1'b0);
        check("t6_m_ar_valid", m_ar_valid, 1'b0);
        check("t6_s_ar_ready", s_ar_ready, '0);
        check("t6_s_r_valid", s_r_valid, '0);
        reset = 1'b0;
        // both lower ports ask; a freshly reset round-robin pointer favours port 1
        port_len[1] = 8'd1;
        port_len[2] = 8'd1;
        pending[1]  = 1;
        pending[2]  = 1;
        plan_grant(1);
        plan_grant(2);
        run_until_done("t6_fresh", 200);
        check("t6_perr_after", protocol_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
